// File: rtl/ahb_lite_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_lite_bus_arbiter
//
// Two-master AHB-Lite arbiter with address/control and write-data muxing.
// Grants the address phase round-robin, never breaks a defined-length burst
// or a locked sequence, caps undefined-length INCR bursts at MAX_INCR beats,
// and tracks the data-phase owner so HWDATA follows the beat in flight.
// All state changes only on HREADY-high edges.
//
// Ports:
//   HCLK, HRESETn            clock, synchronous active-low reset
//   HBUSREQ[1:0], HLOCK[1:0] per-master request / lock request
//   H*_M0, H*_M1             per-master address-phase controls and write data
//   HREADY                   shared bus ready from the slave response mux
//   HGRANT[1:0]              registered one-hot grant
//   HMASTER                  address-phase owner (index of HGRANT)
//   HMASTER_D                data-phase owner
//   HMASTLOCK                registered lock of the current owner
//   HADDR..HBURST            address-phase signals muxed by HMASTER
//   HWDATA                   write data muxed by HMASTER_D
// ---------------------------------------------------------------------------
module ahb_lite_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_INCR = 16,
    parameter int PARK     = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [1:0]        HBUSREQ,
    input  logic [1:0]        HLOCK,
    input  logic [ADDR_W-1:0] HADDR_M0,
    input  logic [ADDR_W-1:0] HADDR_M1,
    input  logic [1:0]        HTRANS_M0,
    input  logic [1:0]        HTRANS_M1,
    input  logic              HWRITE_M0,
    input  logic              HWRITE_M1,
    input  logic [2:0]        HSIZE_M0,
    input  logic [2:0]        HSIZE_M1,
    input  logic [2:0]        HBURST_M0,
    input  logic [2:0]        HBURST_M1,
    input  logic [DATA_W-1:0] HWDATA_M0,
    input  logic [DATA_W-1:0] HWDATA_M1,
    input  logic              HREADY,
    output logic [1:0]        HGRANT,
    output logic              HMASTER,
    output logic              HMASTER_D,
    output logic              HMASTLOCK,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic       PARK_S     = (PARK != 0);
    localparam logic [7:0] MAX_INCR_S = 8'(MAX_INCR);

    // Beats in a burst; undefined-length INCR is treated as MAX_INCR beats.
    function automatic logic [7:0] burst_len(input logic [2:0] hburst);
        logic [7:0] len;
        case (hburst)
            3'b000:         len = 8'd1;
            3'b001:         len = MAX_INCR_S;
            3'b010, 3'b011: len = 8'd4;
            3'b100, 3'b101: len = 8'd8;
            3'b110, 3'b111: len = 8'd16;
            default:        len = 8'd1;
        endcase
        return len;
    endfunction

    logic [1:0] grant_r;
    logic       owner_r;       // address-phase owner, doubles as last-granted
    logic       owner_d_r;
    logic       mastlock_r;
    logic [7:0] beats_left_r;

    logic [1:0] own_trans_s;
    logic [2:0] own_burst_s;
    logic [7:0] own_len_s;
    logic       other_s;
    logic       arb_s;
    logic       next_owner_s;
    logic [7:0] beats_next_s;

    // Address/control mux follows the address-phase owner.
    always_comb begin
        HADDR  = HADDR_M0;
        HTRANS = HTRANS_M0;
        HWRITE = HWRITE_M0;
        HSIZE  = HSIZE_M0;
        HBURST = HBURST_M0;
        if (owner_r) begin
            HADDR  = HADDR_M1;
            HTRANS = HTRANS_M1;
            HWRITE = HWRITE_M1;
            HSIZE  = HSIZE_M1;
            HBURST = HBURST_M1;
        end else begin
            HADDR  = HADDR_M0;
            HTRANS = HTRANS_M0;
            HWRITE = HWRITE_M0;
            HSIZE  = HSIZE_M0;
            HBURST = HBURST_M0;
        end
    end

    // Write data follows the data-phase owner, one accepted beat behind.
    always_comb begin
        HWDATA = HWDATA_M0;
        if (owner_d_r) begin
            HWDATA = HWDATA_M1;
        end else begin
            HWDATA = HWDATA_M0;
        end
    end

    assign own_trans_s = HTRANS;
    assign own_burst_s = HBURST;
    assign own_len_s   = burst_len(own_burst_s);
    assign other_s     = ~owner_r;

    // Arbitration point: only at the end of a burst, an idle slot, or a
    // capped INCR, and never while the owner holds the bus locked.
    always_comb begin
        arb_s = 1'b0;
        if (HREADY && !mastlock_r) begin
            case (own_trans_s)
                TR_IDLE:   arb_s = 1'b1;
                TR_NONSEQ: arb_s = (own_len_s == 8'd1);
                TR_SEQ:    arb_s = (beats_left_r == 8'd1);
                TR_BUSY:   arb_s = 1'b0;
                default:   arb_s = 1'b0;
            endcase
        end else begin
            arb_s = 1'b0;
        end
    end

    // Round-robin choice: prefer the other master, then the current one,
    // else park.
    always_comb begin
        next_owner_s = owner_r;
        if (arb_s) begin
            if (HBUSREQ[other_s]) begin
                next_owner_s = other_s;
            end else if (HBUSREQ[owner_r]) begin
                next_owner_s = owner_r;
            end else begin
                next_owner_s = PARK_S;
            end
        end else begin
            next_owner_s = owner_r;
        end
    end

    // Remaining-beat tracking of the owner's burst; saturates at zero so an
    // INCR continued past the cap simply runs on without re-arbitration.
    always_comb begin
        beats_next_s = beats_left_r;
        case (own_trans_s)
            TR_NONSEQ: beats_next_s = own_len_s - 8'd1;
            TR_SEQ:    beats_next_s = (beats_left_r == 8'd0) ? 8'd0 : beats_left_r - 8'd1;
            default:   beats_next_s = beats_left_r;
        endcase
    end

    // Grant, owner, lock and beat state advance only on accepted beats.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            grant_r      <= PARK_S ? 2'b10 : 2'b01;
            owner_r      <= PARK_S;
            owner_d_r    <= PARK_S;
            mastlock_r   <= 1'b0;
            beats_left_r <= 8'd0;
        end else if (HREADY) begin
            grant_r      <= next_owner_s ? 2'b10 : 2'b01;
            owner_r      <= next_owner_s;
            owner_d_r    <= owner_r;
            mastlock_r   <= HLOCK[next_owner_s];
            beats_left_r <= beats_next_s;
        end
    end

    assign HGRANT    = grant_r;
    assign HMASTER   = owner_r;
    assign HMASTER_D = owner_d_r;
    assign HMASTLOCK = mastlock_r;

endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// Self-checking bench for ahb_lite_bus_arbiter (MAX_INCR = 4, PARK = 0).
// Each step drives one cycle of master stimulus and pushes the state the
// arbiter must show after that edge; the scenario task pops and compares.
module tb_ahb_lite_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;
    localparam logic [2:0] SG = 3'b000;
    localparam logic [2:0] IN = 3'b001;
    localparam logic [2:0] I4 = 3'b011;
    localparam logic [2:0] W8 = 3'b100;
    localparam logic [2:0] I16 = 3'b111;

    // expected {HGRANT, HMASTER, HMASTER_D, HMASTLOCK}
    localparam logic [4:0] G0     = 5'b01_0_0_0;
    localparam logic [4:0] G0D1   = 5'b01_0_1_0;
    localparam logic [4:0] G0L    = 5'b01_0_0_1;
    localparam logic [4:0] G1D0   = 5'b10_1_0_0;
    localparam logic [4:0] G1D1   = 5'b10_1_1_0;
    localparam logic [4:0] G1D0L  = 5'b10_1_0_1;
    localparam logic [4:0] G1D1L  = 5'b10_1_1_1;

    logic          HCLK, HRESETn, HREADY;
    logic [1:0]    HBUSREQ, HLOCK;
    logic [AW-1:0] HADDR_M0, HADDR_M1, HADDR;
    logic [1:0]    HTRANS_M0, HTRANS_M1, HTRANS;
    logic          HWRITE_M0, HWRITE_M1, HWRITE;
    logic [2:0]    HSIZE_M0, HSIZE_M1, HSIZE;
    logic [2:0]    HBURST_M0, HBURST_M1, HBURST;
    logic [DW-1:0] HWDATA_M0, HWDATA_M1, HWDATA;
    logic [1:0]    HGRANT;
    logic          HMASTER, HMASTER_D, HMASTLOCK;

    typedef struct packed {
        logic       rst_n;
        logic       rdy;
        logic [1:0] req;
        logic [1:0] lock;
        logic [1:0] tr0;
        logic [2:0] bu0;
        logic [1:0] tr1;
        logic [2:0] bu1;
        logic [4:0] exp;
    } step_t;

    typedef struct packed {
        logic [4:0]  st;
        logic [72:0] mux;   // {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA}
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    ahb_lite_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_INCR(4), .PARK(0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
        .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1),
        .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1),
        .HBURST_M0(HBURST_M0), .HBURST_M1(HBURST_M1),
        .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1),
        .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER),
        .HMASTER_D(HMASTER_D), .HMASTLOCK(HMASTLOCK),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    function automatic step_t mk(input logic rst_n, input logic rdy,
                                 input logic [1:0] req, input logic [1:0] lock,
                                 input logic [1:0] tr0, input logic [2:0] bu0,
                                 input logic [1:0] tr1, input logic [2:0] bu1,
                                 input logic [4:0] exp);
        step_t s;
        s.rst_n = rst_n; s.rdy = rdy; s.req = req; s.lock = lock;
        s.tr0 = tr0; s.bu0 = bu0; s.tr1 = tr1; s.bu1 = bu1; s.exp = exp;
        return s;
    endfunction

    // Drive one cycle and record what must be visible after the next edge.
    task automatic drive(input step_t s);
        sb_t e;
        HRESETn   = s.rst_n;
        HREADY    = s.rdy;
        HBUSREQ   = s.req;
        HLOCK     = s.lock;
        HTRANS_M0 = s.tr0;
        HBURST_M0 = s.bu0;
        HTRANS_M1 = s.tr1;
        HBURST_M1 = s.bu1;
        HADDR_M0  = 32'h0000_1000 + 32'(cyc * 4);
        HADDR_M1  = 32'h0000_8000 + 32'(cyc * 4);
        HWDATA_M0 = 32'hA000_0000 | 32'(cyc);
        HWDATA_M1 = 32'hB000_0000 | 32'(cyc);
        HWRITE_M0 = 1'b1;
        HWRITE_M1 = 1'b0;
        HSIZE_M0  = 3'b010;
        HSIZE_M1  = 3'b001;
        e.st = s.exp;
        if (s.exp[2])
            e.mux[72:32] = {HADDR_M1, HTRANS_M1, HWRITE_M1, HSIZE_M1, HBURST_M1};
        else
            e.mux[72:32] = {HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0, HBURST_M0};
        e.mux[31:0] = s.exp[1] ? HWDATA_M1 : HWDATA_M0;
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic test_reset();
        step_t t[$];
        sb_t e;
        t.push_back(mk(1'b0, 1'b1, 2'b10, 2'b10, NS, SG, SQ, I4, G0));
        t.push_back(mk(1'b0, 1'b1, 2'b10, 2'b10, NS, SG, SQ, I4, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, ID, SG, ID, SG, G0));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge HCLK); #1;
            e = sb_q.pop_front();
            total++;
            if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== e.st) begin
                bad++;
                $display("FAIL reset state step %0d: got %b want %b", i, {HGRANT, HMASTER, HMASTER_D, HMASTLOCK}, e.st);
            end
            total++;
            if ({HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA} !== e.mux) begin
                bad++;
                $display("FAIL reset mux step %0d: got %h want %h", i, {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA}, e.mux);
            end
            if (i == 1) begin
                total++;
                if (HTRANS !== 2'b10) begin
                    bad++;
                    $display("FAIL reset htrans: got %b want 10", HTRANS);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        step_t t[$];
        sb_t e;
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, NS, SG, NS, SG, G1D0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, NS, SG, NS, SG, G0D1));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, NS, SG, NS, SG, G1D0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, NS, SG, NS, SG, G0D1));
        t.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, ID, SG, ID, SG, G0));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge HCLK); #1;
            e = sb_q.pop_front();
            total++;
            if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== e.st) begin
                bad++;
                $display("FAIL rr state step %0d: got %b want %b", i, {HGRANT, HMASTER, HMASTER_D, HMASTLOCK}, e.st);
            end
            total++;
            if ({HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA} !== e.mux) begin
                bad++;
                $display("FAIL rr mux step %0d: got %h want %h", i, {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA}, e.mux);
            end
        end
    endtask

    task automatic test_burst_integrity();
        step_t t[$];
        sb_t e;
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, NS, I4, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, SQ, I4, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, SQ, I4, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, SQ, I4, ID, SG, G1D0));
        t.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, ID, SG, NS, SG, G0D1));
        t.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, ID, SG, ID, SG, G0));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge HCLK); #1;
            e = sb_q.pop_front();
            total++;
            if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== e.st) begin
                bad++;
                $display("FAIL burst state step %0d: got %b want %b", i, {HGRANT, HMASTER, HMASTER_D, HMASTLOCK}, e.st);
            end
            total++;
            if ({HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA} !== e.mux) begin
                bad++;
                $display("FAIL burst mux step %0d: got %h want %h", i, {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA}, e.mux);
            end
        end
    endtask

    task automatic test_wait_states();
        step_t t[$];
        sb_t e;
        t.push_back(mk(1'b1, 1'b1, 2'b10, 2'b00, ID, SG, ID, SG, G1D0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, NS, SG, NS, W8, G1D1));
        for (int k = 0; k < 3; k++)
            t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, NS, SG, SQ, W8, G1D1));
        for (int k = 0; k < 3; k++)
            t.push_back(mk(1'b1, 1'b0, 2'b11, 2'b00, NS, SG, SQ, W8, G1D1));
        for (int k = 0; k < 3; k++)
            t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, NS, SG, SQ, W8, G1D1));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, NS, SG, SQ, W8, G0D1));
        t.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, NS, SG, ID, SG, G0));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge HCLK); #1;
            e = sb_q.pop_front();
            total++;
            if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== e.st) begin
                bad++;
                $display("FAIL wait state step %0d: got %b want %b", i, {HGRANT, HMASTER, HMASTER_D, HMASTLOCK}, e.st);
            end
            total++;
            if ({HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA} !== e.mux) begin
                bad++;
                $display("FAIL wait mux step %0d: got %h want %h", i, {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA}, e.mux);
            end
        end
    endtask

    task automatic test_lock();
        step_t t[$];
        sb_t e;
        t.push_back(mk(1'b1, 1'b1, 2'b01, 2'b01, ID, SG, ID, SG, G0L));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b01, NS, SG, ID, SG, G0L));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b01, NS, SG, ID, SG, G0L));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b01, ID, SG, ID, SG, G0L));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, ID, SG, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b10, 2'b00, ID, SG, ID, SG, G1D0));
        t.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, ID, SG, NS, SG, G0D1));
        t.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, ID, SG, ID, SG, G0));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge HCLK); #1;
            e = sb_q.pop_front();
            total++;
            if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== e.st) begin
                bad++;
                $display("FAIL lock state step %0d: got %b want %b", i, {HGRANT, HMASTER, HMASTER_D, HMASTLOCK}, e.st);
            end
            total++;
            if ({HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA} !== e.mux) begin
                bad++;
                $display("FAIL lock mux step %0d: got %h want %h", i, {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA}, e.mux);
            end
        end
    endtask

    task automatic test_incr_cap();
        step_t t[$];
        sb_t e;
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, NS, IN, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, SQ, IN, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, SQ, IN, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, SQ, IN, ID, SG, G1D0));
        t.push_back(mk(1'b1, 1'b1, 2'b01, 2'b00, SQ, IN, ID, SG, G0D1));
        t.push_back(mk(1'b1, 1'b1, 2'b01, 2'b00, NS, IN, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b01, 2'b00, SQ, IN, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b01, 2'b00, SQ, IN, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b01, 2'b00, SQ, IN, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, SQ, IN, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b11, 2'b00, SQ, IN, ID, SG, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, ID, SG, ID, SG, G0));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge HCLK); #1;
            e = sb_q.pop_front();
            total++;
            if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== e.st) begin
                bad++;
                $display("FAIL incr state step %0d: got %b want %b", i, {HGRANT, HMASTER, HMASTER_D, HMASTLOCK}, e.st);
            end
            total++;
            if ({HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA} !== e.mux) begin
                bad++;
                $display("FAIL incr mux step %0d: got %h want %h", i, {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA}, e.mux);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        step_t t[$];
        sb_t e;
        t.push_back(mk(1'b1, 1'b1, 2'b10, 2'b10, ID, SG, ID, SG, G1D0L));
        t.push_back(mk(1'b1, 1'b1, 2'b10, 2'b10, ID, SG, NS, I16, G1D1L));
        t.push_back(mk(1'b1, 1'b1, 2'b10, 2'b10, ID, SG, SQ, I16, G1D1L));
        t.push_back(mk(1'b0, 1'b1, 2'b10, 2'b10, ID, SG, SQ, I16, G0));
        t.push_back(mk(1'b1, 1'b1, 2'b01, 2'b00, NS, SG, SQ, I16, G0));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge HCLK); #1;
            e = sb_q.pop_front();
            total++;
            if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== e.st) begin
                bad++;
                $display("FAIL midrst state step %0d: got %b want %b", i, {HGRANT, HMASTER, HMASTER_D, HMASTLOCK}, e.st);
            end
            total++;
            if ({HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA} !== e.mux) begin
                bad++;
                $display("FAIL midrst mux step %0d: got %h want %h", i, {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA}, e.mux);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_integrity();
        test_wait_states();
        test_lock();
        test_incr_cap();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
